// File: rtl/prime_pkg.sv
// Shared types and constants for the 4-bit prime scan datapath.
package prime_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT,
    DONE
  } state_t;

  // Bit n is set when n is prime: 2, 3, 5, 7, 11, 13.
  localparam logic [15:0] PRIME_MASK = 16'h28AC;
  localparam int          MAX_PRIMES = 6;

endpackage

// File: rtl/prime4_check.sv
// Combinational 4-bit prime detector implemented as a mask lookup.
module prime4_check
  import prime_pkg::*;
(
  input  logic [3:0] in,
  output logic       is_prime
);

  assign is_prime = PRIME_MASK[in];

endmodule

// File: rtl/prime_scan_ctrl.sv
// Sweeps [lo, hi] through the prime detector, streams primes over valid/ready
// and reports how many were accepted when the sweep ends.
module prime_scan_ctrl
  import prime_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] lo,
  input  logic [3:0] hi,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic [2:0] prime_cnt,
  output logic       done,
  output logic       err
);

  state_t     state, state_n;
  logic [3:0] cur, cur_n;
  logic [3:0] lim, lim_n;
  logic [3:0] data_n;
  logic       valid_n;
  logic [2:0] cnt_n;
  logic       err_n;
  logic       is_prime;

  prime4_check u_check (
    .in       (cur),
    .is_prime (is_prime)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur       <= 4'd0;
      lim       <= 4'd0;
      out_data  <= 4'd0;
      out_valid <= 1'b0;
      prime_cnt <= 3'd0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cur       <= cur_n;
      lim       <= lim_n;
      out_data  <= data_n;
      out_valid <= valid_n;
      prime_cnt <= cnt_n;
      err       <= err_n;
    end
  end

  // cur is compared against lim before incrementing so hi=15 never wraps.
  always_comb begin
    state_n = state;
    cur_n   = cur;
    lim_n   = lim;
    data_n  = out_data;
    valid_n = out_valid;
    cnt_n   = prime_cnt;
    err_n   = err;
    case (state)
      IDLE: begin
        if (start) begin
          cur_n = lo;
          lim_n = hi;
          cnt_n = 3'd0;
          if (lo > hi) begin
            err_n   = 1'b1;
            state_n = DONE;
          end else begin
            err_n   = 1'b0;
            state_n = SCAN;
          end
        end
      end
      SCAN: begin
        if (is_prime) begin
          data_n  = cur;
          valid_n = 1'b1;
          state_n = EMIT;
        end else if (cur == lim) begin
          state_n = DONE;
        end else begin
          cur_n = cur + 4'd1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          cnt_n   = prime_cnt + 3'd1;
          valid_n = 1'b0;
          if (cur == lim) begin
            state_n = DONE;
          end else begin
            cur_n   = cur + 4'd1;
            state_n = SCAN;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state == SCAN) || (state == EMIT);
  assign done = (state == DONE);

endmodule

// File: doc/prime_scan_ctrl.md
# prime_scan_ctrl

Sequencer that sweeps an inclusive 4-bit range [lo, hi] through a 4-bit combinational prime detector. It streams each prime found out over a valid/ready handshake and reports the total count when the sweep ends. It sits between a host control interface and the shared prime-detect datapath, and evaluates one candidate per cycle.

## Interface
- No parameters; the datapath is fixed at 4 bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- start  in  1  sweep request; sampled only in IDLE
- lo  in  4  first candidate; sampled with start
- hi  in  4  last candidate, inclusive; sampled with start
- busy  out  1  high in SCAN and EMIT
- out_valid  out  1  prime available on out_data
- out_ready  in  1  consumer accepts out_data
- out_data  out  4  prime value
- prime_cnt  out  3  primes accepted in the current or last sweep; maximum 6
- done  out  1  one-cycle pulse at end of sweep
- err  out  1  high when the last request had lo > hi; held until the next accepted start

## Operation
- States: IDLE, SCAN, EMIT, DONE.
- IDLE, start=1:
  - Latch lo into cur and hi into lim.
  - Clear prime_cnt and err.
  - If lo > hi: go to DONE and set err=1.
  - Otherwise: go to SCAN.
- IDLE, start=0: stay in IDLE.
- SCAN: cur drives the detector.
  - is_prime=1: register out_data=cur, set out_valid=1, go to EMIT.
  - is_prime=0 and cur==lim: go to DONE.
  - Otherwise: cur = cur+1, stay in SCAN.
- EMIT: hold out_valid and out_data stable until out_valid & out_ready.
  - On handshake: prime_cnt = prime_cnt+1 and out_valid=0.
  - Then, if cur==lim, go to DONE; otherwise cur = cur+1 and go to SCAN.
- DONE: done=1 for exactly one cycle, then IDLE.
- Detector function: primes are 2, 3, 5, 7, 11, 13. 0 and 1 are not prime.
- Wrap-around: compare cur==lim before incrementing. hi=15 must never wrap cur to 0 and rescan.
- lo==hi: exactly one candidate is evaluated.
- start while busy or in DONE: ignored, with no effect on the sweep in progress.
- Reset, including mid-sweep:
  - state=IDLE; cur, lim, out_data, prime_cnt = 0.
  - out_valid, busy, done, err = 0.
  - Any pending out_valid is dropped.

## Timing
- start sampled at edge t. busy=1 from t+1, and the first candidate is evaluated in cycle t+1.
- Non-prime candidate: 1 cycle in SCAN.
- Prime candidate:
  - 1 cycle in SCAN.
  - out_valid rises on the next edge.
  - At least 1 cycle in EMIT (exactly 1 when out_ready=1).
- Full sweep 0..15 with out_ready tied high:
  - busy for 22 cycles (16 SCAN + 6 EMIT).
  - done pulses in the following cycle.
- Error path: done pulses at t+1, err=1 from t+1, busy never asserts.
- prime_cnt updates on the handshake edge. It is valid when done pulses and holds until the next accepted start.
- Outputs are registered, with no combinational path from out_ready to out_valid. busy is decoded from state registers only.

## Structure
- Package prime_pkg holds:
  - state enum (IDLE, SCAN, EMIT, DONE)
  - constant PRIME_MASK = 16'h28AC (bit n set when n is prime)
  - constant MAX_PRIMES = 6
- One sub-module, prime4_check: combinational, in[3:0] -> is_prime, implemented as a PRIME_MASK lookup.
- The controller instantiates it once and drives it from cur.

## Test plan
- Reset, then lo=0, hi=15, start pulse, out_ready=1:
  - out_data sequence 2, 3, 5, 7, 11, 13.
  - busy high for 22 cycles.
  - done then pulses; prime_cnt=6, err=0.
- lo=8, hi=15, out_ready low for 5 cycles after the first out_valid:
  - out_data=11 held stable for all 5 cycles.
  - Then 11, 13 accepted; prime_cnt=2.
- lo=9, hi=9 → no out_valid, done one cycle after busy's single cycle, prime_cnt=0.
- lo=12, hi=3 → err=1 and done one cycle after start, busy stays 0, prime_cnt=0.
- lo=hi=15 → cur never wraps, no output, done.
- Mid-sweep case:
  - Assert rst_n=0 during EMIT of value 5 → all outputs 0 immediately.
  - After release, new start with lo=2, hi=3 → outputs 2, 3, prime_cnt=2.
- start pulsed during busy → ignored; the current sweep results are unchanged.
